// File: rtl/legv8_control_unit.sv
// LEGv8 multi-cycle control unit: sequences FETCH/DECODE/EX0/EX1/HALT and drives registered ControlWord/constant.
// Optional build macro LEGV8_CU_FLAGSET_EN adds ADDS/SUBS and B.cond.
module legv8_control_unit #(
  parameter bit RESET_STATE_HALT = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] IR,
  input  logic [3:0]  status,
  output logic [39:0] ControlWord,
  output logic [63:0] constant,
  output logic [2:0]  state,
  output logic        halted
);

  typedef enum logic [2:0] {
    FETCH = 3'd0, DECODE = 3'd1, EX0 = 3'd2, EX1 = 3'd3, HALT = 3'd7
  } state_t;

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_ADDS, OP_SUBS, OP_ADDI, OP_SUBI,
    OP_LDUR, OP_STUR, OP_B, OP_CBZ, OP_BCOND, OP_BAD
  } op_t;

  typedef struct packed {
    logic [5:0] rsvd_hi;
    logic       sl;
    logic [1:0] bus;
    logic [1:0] ps;
    logic       pc_en;
    logic       bsel;
    logic       ir_ld;
    logic       rsvd_lo;
    logic [4:0] fs;
    logic       c0;
    logic [1:0] size;
    logic       mem_w;
    logic       reg_w;
    logic [4:0] da;
    logic [4:0] sa;
    logic [4:0] sb;
  } cw_t;

  localparam logic [4:0] FS_AND    = 5'b00000;
  localparam logic [4:0] FS_ORR    = 5'b00100;
  localparam logic [4:0] FS_ADD    = 5'b01000;
  localparam logic [4:0] FS_SUB    = 5'b01001;
  localparam logic [4:0] FS_PASS_A = 5'b01100;
  localparam cw_t    NOP_CW      = cw_t'(40'h00_0006_7FFF);
  localparam state_t START_STATE = RESET_STATE_HALT ? HALT : FETCH;

  function automatic op_t decode(input logic [10:0] opc);
    op_t op;
    op = OP_BAD;
    if (opc == 11'b10001011000)        op = OP_ADD;
    if (opc == 11'b11001011000)        op = OP_SUB;
    if (opc == 11'b10001010000)        op = OP_AND;
    if (opc == 11'b10101010000)        op = OP_ORR;
    if (opc[10:1] == 10'b1001000100)   op = OP_ADDI;
    if (opc[10:1] == 10'b1101000100)   op = OP_SUBI;
    if (opc == 11'b11111000010)        op = OP_LDUR;
    if (opc == 11'b11111000000)        op = OP_STUR;
    if (opc[10:5] == 6'b000101)        op = OP_B;
    if (opc[10:3] == 8'b10110100)      op = OP_CBZ;
`ifdef LEGV8_CU_FLAGSET_EN
    if (opc == 11'b10101011000)        op = OP_ADDS;
    if (opc == 11'b11101011000)        op = OP_SUBS;
    if (opc[10:3] == 8'b01010100)      op = OP_BCOND;
`endif
    return op;
  endfunction

  // Full ARMv8 condition table on {V,C,N,Z}, masked down to EQ/NE/GE/LT/GT/LE.
  function automatic logic cond_true(input logic [3:0] cond, input logic [3:0] flags);
    logic        z, n, c, v;
    logic [15:0] tbl;
    z = flags[0];
    n = flags[1];
    c = flags[2];
    v = flags[3];
    tbl = {1'b1, 1'b1, z | (n ^ v), ~z & ~(n ^ v), n ^ v, ~(n ^ v), ~(c & ~z), c & ~z,
           ~v, v, ~n, n, ~c, c, ~z, z};
    return tbl[cond] & ((16'h3C03 >> cond) & 16'd1) != 16'd0;
  endfunction

  state_t      state_reg, state_next;
  cw_t         cw_reg, cw_next;
  logic [63:0] const_reg, const_next;
  op_t         op_reg, op_next, op_dec;
  logic [4:0]  rd_reg, rd_next, rn_reg, rn_next;
  logic        boot_reg, halted_reg, branch_taken;

  assign op_dec       = decode(IR[31:21]);
  assign branch_taken = cond_true((op_reg == OP_CBZ) ? 4'b0000 : rd_reg[3:0], status);

  always_comb begin
    state_next = state_reg;
    op_next    = op_reg;
    rd_next    = rd_reg;
    rn_next    = rn_reg;
    const_next = const_reg;
    if (boot_reg) begin
      state_next = START_STATE;
    end else begin
      case (state_reg)
        FETCH:  state_next = DECODE;
        DECODE: begin
          op_next    = op_dec;
          rd_next    = IR[4:0];
          rn_next    = IR[9:5];
          const_next = '0;
          case (op_dec)
            OP_ADDI, OP_SUBI:  const_next = {52'd0, IR[21:10]};
            OP_LDUR, OP_STUR:  const_next = {{55{IR[20]}}, IR[20:12]};
            OP_B:              const_next = {{36{IR[25]}}, IR[25:0], 2'b00};
            OP_CBZ, OP_BCOND:  const_next = {{43{IR[23]}}, IR[23:5], 2'b00};
            default:           const_next = '0;
          endcase
          state_next = (op_dec == OP_BAD) ? HALT : EX0;
        end
        EX0:     state_next = (op_reg inside {OP_LDUR, OP_CBZ, OP_BCOND}) ? EX1 : FETCH;
        EX1:     state_next = FETCH;
        default: state_next = HALT;
      endcase
    end
  end

  // The word for the state being entered is built here so it is registered alongside it.
  always_comb begin
    cw_next = NOP_CW;
    case (state_next)
      FETCH: begin
        cw_next.bus   = 2'b11;
        cw_next.ir_ld = 1'b1;
        cw_next.pc_en = 1'b1;
        cw_next.ps    = 2'b01;
      end
      EX0: begin
        case (op_next)
          OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_ADDS, OP_SUBS: begin
            cw_next.da    = rd_next;
            cw_next.sa    = rn_next;
            cw_next.sb    = IR[20:16];
            cw_next.reg_w = 1'b1;
            cw_next.bus   = 2'b00;
            cw_next.fs    = (op_next == OP_AND) ? FS_AND :
                            (op_next == OP_ORR) ? FS_ORR :
                            (op_next == OP_SUB || op_next == OP_SUBS) ? FS_SUB : FS_ADD;
            cw_next.c0    = (op_next == OP_SUB) || (op_next == OP_SUBS);
            cw_next.sl    = (op_next == OP_ADDS) || (op_next == OP_SUBS);
          end
          OP_ADDI, OP_SUBI: begin
            cw_next.fs    = (op_next == OP_SUBI) ? FS_SUB : FS_ADD;
            cw_next.c0    = (op_next == OP_SUBI);
            cw_next.bsel  = 1'b1;
            cw_next.reg_w = 1'b1;
            cw_next.da    = rd_next;
            cw_next.sa    = rn_next;
          end
          OP_LDUR: begin
            cw_next.fs   = FS_ADD;
            cw_next.bsel = 1'b1;
            cw_next.sa   = rn_next;
          end
          OP_STUR: begin
            cw_next.fs    = FS_ADD;
            cw_next.bsel  = 1'b1;
            cw_next.sa    = rn_next;
            cw_next.sb    = rd_next;
            cw_next.bus   = 2'b01;
            cw_next.mem_w = 1'b1;
          end
          OP_B: begin
            cw_next.ps    = 2'b11;
            cw_next.pc_en = 1'b1;
          end
          OP_CBZ: begin
            cw_next.sa = rd_next;
            cw_next.fs = FS_PASS_A;
            cw_next.sl = 1'b1;
          end
          default: cw_next = NOP_CW;
        endcase
      end
      EX1: begin
        if (op_reg == OP_LDUR) begin
          cw_next.fs    = FS_ADD;
          cw_next.bsel  = 1'b1;
          cw_next.sa    = rn_reg;
          cw_next.bus   = 2'b11;
          cw_next.reg_w = 1'b1;
          cw_next.da    = rd_reg;
        end else if (branch_taken) begin
          cw_next.ps    = 2'b11;
          cw_next.pc_en = 1'b1;
        end
      end
      default: cw_next = NOP_CW;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg  <= START_STATE;
      cw_reg     <= NOP_CW;
      const_reg  <= '0;
      halted_reg <= 1'b0;
      boot_reg   <= 1'b1;
      op_reg     <= OP_BAD;
      rd_reg     <= '0;
      rn_reg     <= '0;
    end else begin
      state_reg  <= state_next;
      cw_reg     <= cw_next;
      const_reg  <= const_next;
      halted_reg <= (state_next == HALT);
      boot_reg   <= 1'b0;
      op_reg     <= op_next;
      rd_reg     <= rd_next;
      rn_reg     <= rn_next;
    end
  end

  assign ControlWord = cw_reg;
  assign constant    = const_reg;
  assign state       = state_reg;
  assign halted      = halted_reg;

endmodule

// File: tb/tb_legv8_control_unit.sv
// Bench for legv8_control_unit: directed test-plan steps plus random instructions against a field-level model.
module tb_legv8_control_unit;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] IR = '0;
  logic [3:0]  status = '0;
  logic [39:0] ControlWord;
  logic [63:0] constant;
  logic [2:0]  state;
  logic        halted;

  int errors = 0;
  int checks = 0;

  legv8_control_unit dut (
    .clock(clock), .reset(reset), .IR(IR), .status(status),
    .ControlWord(ControlWord), .constant(constant), .state(state), .halted(halted)
  );

  always #5 clock = ~clock;

  localparam logic [39:0] NOP = 40'h00_0006_7FFF;
  localparam int NK = 13;
`ifdef LEGV8_CU_FLAGSET_EN
  localparam bit FLAGSET = 1'b1;
`else
  localparam bit FLAGSET = 1'b0;
`endif

  // Opcode table: ADD SUB AND ORR ADDS SUBS ADDI SUBI LDUR STUR B CBZ B.cond
  logic [31:0] k_mask [NK] = '{32'hFFE00000, 32'hFFE00000, 32'hFFE00000, 32'hFFE00000, 32'hFFE00000,
                               32'hFFE00000, 32'hFFC00000, 32'hFFC00000, 32'hFFE00000, 32'hFFE00000,
                               32'hFC000000, 32'hFF000000, 32'hFF000000};
  logic [31:0] k_val  [NK] = '{32'h8B000000, 32'hCB000000, 32'h8A000000, 32'hAA000000, 32'hAB000000,
                               32'hEB000000, 32'h91000000, 32'hD1000000, 32'hF8400000, 32'hF8000000,
                               32'h14000000, 32'hB4000000, 32'h54000000};
  string k_name [NK] = '{"ADD", "SUB", "AND", "ORR", "ADDS", "SUBS", "ADDI", "SUBI",
                         "LDUR", "STUR", "B", "CBZ", "BCOND"};

  logic [39:0] exp_cw [4];
  logic [2:0]  exp_st [4];
  int          exp_n;
  logic [63:0] exp_k;
  bit          exp_k_chk;
  bit          exp_halt;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int classify(input logic [31:0] ir);
    for (int i = 0; i < NK; i++) begin
      if (!FLAGSET && (i == 4 || i == 5 || i == 12)) continue;
      if ((ir & k_mask[i]) == k_val[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [39:0] put(input logic [39:0] w, input int lsb, input int width, input int val);
    logic [39:0] m;
    m = ((40'd1 << width) - 40'd1) << lsb;
    return (w & ~m) | ((40'(val) << lsb) & m);
  endfunction

  function automatic logic [63:0] sext(input longint v, input int bits);
    longint x;
    x = v;
    if (x >= (longint'(1) << (bits - 1))) x = x - (longint'(1) << bits);
    return 64'(x);
  endfunction

  function automatic bit cond_ok(input logic [3:0] cond, input logic [3:0] st);
    bit z, n, v;
    z = st[0]; n = st[1]; v = st[3];
    case (cond)
      4'd0:    return z;
      4'd1:    return !z;
      4'd10:   return n == v;
      4'd11:   return n != v;
      4'd12:   return !z && (n == v);
      4'd13:   return z || (n != v);
      default: return 1'b0;
    endcase
  endfunction

  // Expected per-cycle words for one instruction, from the field rules of the instruction set.
  task automatic model(input logic [31:0] ir, input logic [3:0] st);
    int k, rd, rn, rm;
    logic [39:0] w, w1, br;
    k  = classify(ir);
    rd = int'(ir[4:0]);
    rn = int'(ir[9:5]);
    rm = int'(ir[20:16]);
    w  = NOP;
    w1 = NOP;
    br = put(put(NOP, 29, 2, 3), 28, 1, 1);
    exp_cw[0] = put(put(put(put(NOP, 31, 2, 3), 26, 1, 1), 28, 1, 1), 29, 2, 1);
    exp_st[0] = 3'd0;
    exp_cw[1] = NOP;
    exp_st[1] = 3'd1;
    exp_st[2] = 3'd2;
    exp_n = 3; exp_k = '0; exp_k_chk = 1'b0; exp_halt = 1'b0;
    case (k)
      0, 1, 2, 3, 4, 5: begin
        w = put(put(put(put(w, 10, 5, rd), 5, 5, rn), 0, 5, rm), 15, 1, 1);
        w = put(w, 20, 5, (k == 0 || k == 4) ? 8 : (k == 1 || k == 5) ? 9 : (k == 2) ? 0 : 4);
        if (k == 1 || k == 5) w = put(w, 19, 1, 1);
        if (k >= 4) w = put(w, 33, 1, 1);
      end
      6, 7: begin
        w = put(put(put(put(put(w, 20, 5, (k == 7) ? 9 : 8), 27, 1, 1), 15, 1, 1), 10, 5, rd), 5, 5, rn);
        if (k == 7) w = put(w, 19, 1, 1);
        exp_k = 64'(ir[21:10]); exp_k_chk = 1'b1;
      end
      8: begin
        w  = put(put(put(w, 20, 5, 8), 27, 1, 1), 5, 5, rn);
        w1 = put(put(put(w, 31, 2, 3), 15, 1, 1), 10, 5, rd);
        exp_n = 4; exp_k = sext(longint'(ir[20:12]), 9); exp_k_chk = 1'b1;
      end
      9: begin
        w = put(put(put(put(put(put(w, 20, 5, 8), 27, 1, 1), 5, 5, rn), 0, 5, rd), 31, 2, 1), 16, 1, 1);
        exp_k = sext(longint'(ir[20:12]), 9); exp_k_chk = 1'b1;
      end
      10: begin
        w = br;
        exp_k = sext(longint'(ir[25:0]), 26) * 4; exp_k_chk = 1'b1;
      end
      11, 12: begin
        if (k == 11) w = put(put(put(w, 5, 5, rd), 20, 5, 12), 33, 1, 1);
        w1 = ((k == 11) ? st[0] : cond_ok(ir[3:0], st)) ? br : NOP;
        exp_n = 4; exp_k = sext(longint'(ir[23:5]), 19) * 4; exp_k_chk = 1'b1;
      end
      default: begin
        exp_halt = 1'b1; exp_st[2] = 3'd7;
      end
    endcase
    exp_cw[2] = w;
    exp_cw[3] = w1;
    exp_st[3] = 3'd3;
  endtask

  task automatic run_instr(input logic [31:0] ir, input logic [3:0] st);
    string nm;
    int k;
    k  = classify(ir);
    nm = (k < 0) ? "BAD" : k_name[k];
    model(ir, st);
    IR = $urandom;
    status = st;
    for (int c = 0; c < exp_n; c++) begin
      tick();
      if (c == 0) IR = ir;
      if (c == 2) IR = $urandom;
      check($sformatf("%s.c%0d.state", nm, c), 64'(state), 64'(exp_st[c]));
      check($sformatf("%s.c%0d.cw", nm, c), 64'(ControlWord), 64'(exp_cw[c]));
      check($sformatf("%s.c%0d.halted", nm, c), 64'(halted), 64'(exp_st[c] == 3'd7));
      if (c >= 2 && exp_k_chk) check($sformatf("%s.c%0d.const", nm, c), constant, exp_k);
    end
    $display("txn %s ir=%h status=%b cycles=%0d", nm, ir, st, exp_n);
  endtask

  task automatic halt_and_reset();
    for (int c = 0; c < 10; c++) begin
      tick();
      check("halt.state", 64'(state), 64'd7);
      check("halt.cw", 64'(ControlWord), 64'(NOP));
      check("halt.flag", 64'(halted), 64'd1);
    end
    reset = 1'b0;
    tick();
    check("halt_rst.state", 64'(state), 64'd0);
    check("halt_rst.cw", 64'(ControlWord), 64'(NOP));
    check("halt_rst.flag", 64'(halted), 64'd0);
    reset = 1'b1;
    $display("txn HALT-RELEASE held 10 cycles then reset");
  endtask

  initial begin
    int k;
    logic [31:0] r, ir;
    logic [3:0]  st;

    reset = 1'b0;
    tick();
    tick();
    check("reset.cw", 64'(ControlWord), 64'h00_0006_7FFF);
    check("reset.state", 64'(state), 64'd0);
    check("reset.halted", 64'(halted), 64'd0);
    check("reset.const", constant, 64'd0);
    reset = 1'b1;

    run_instr(32'h8B020023, 4'b0000);
    run_instr(32'hF84083E2, 4'b0000);
    check("ldur.const_literal", constant, 64'd8);
    run_instr(32'hB4FFFFC1, 4'b0001);
    check("cbz.const_literal", constant, 64'hFFFF_FFFF_FFFF_FFF8);
    run_instr(32'hB4FFFFC1, 4'b0000);
    run_instr(32'hFFFFFFFF, 4'b0000);
    halt_and_reset();

    // Reset during LDUR EX0 must abort the write-back.
    IR = 32'hF84083E2;
    tick();
    tick();
    tick();
    check("abort.ex0_state", 64'(state), 64'd2);
    reset = 1'b0;
    tick();
    check("abort.cw", 64'(ControlWord), 64'(NOP));
    check("abort.regw_memw", 64'(ControlWord[16:15]), 64'd0);
    check("abort.state", 64'(state), 64'd0);
    reset = 1'b1;
    $display("txn LDUR-ABORT reset in EX0");

    for (int i = 0; i < 80; i++) begin
      k  = int'($urandom_range(NK - 1, 0));
      r  = $urandom;
      st = 4'($urandom);
      ir = (r & ~k_mask[k]) | k_val[k];
      run_instr(ir, st);
      if (exp_halt) halt_and_reset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/legv8_control_unit.md
Name: legv8_control_unit

Overview:
- Multi-cycle control FSM for the LEGv8 datapath.
- Sits directly upstream of `LEGv8_Datapath_TS`. It consumes `IR_out` and `current_status`, and drives that datapath's `ControlWord` and `constant` inputs every cycle.
- Sequences FETCH, DECODE and 1–2 execute cycles for a fixed instruction subset, and halts on an unsupported opcode.

Parameters:
- RESET_STATE_HALT, 0, when 1 the FSM leaves reset in HALT instead of FETCH (bring-up only).

Ports:
- clock  input  1  rising-edge clock, single domain.
- reset  input  1  synchronous, active-low reset (sampled on the rising edge of clock).
- IR  input  32  instruction register contents from the datapath.
- status  input  4  registered flags {V,C,N,Z} from the datapath.
- ControlWord  output  40  registered control word to the datapath.
- constant  output  64  registered immediate to the datapath.
- state  output  3  current FSM state (debug).
- halted  output  1  high while in HALT.

Behaviour:
- ControlWord fields are decided as follows:
  - [39:34] reserved, driven 0.
  - [33] SL, status load.
  - [32:31] data-bus select: 00 ALU, 01 register B to memory, 10 PC, 11 memory.
  - [30:29] PS: 00 hold, 01 PC+4, 10 load constant, 11 PC+constant.
  - [28] PC_En.
  - [27] BSel, selects constant.
  - [26] IR_Ld.
  - [25] reserved.
  - [24:20] FS: 00000 AND, 00100 ORR, 01000 ADD, 01001 SUB, 01100 pass A.
  - [19] C0.
  - [18:17] size, always 11.
  - [16] MemW.
  - [15] RegW.
  - [14:10] DA, [9:5] SA, [4:0] SB.
- NOP word: all fields 0 except size=11 and SA=SB=DA=31.
- All outputs are registered and update on the clock edge.
- Reset (reset==0 at an edge):
  - state=FETCH (or HALT when RESET_STATE_HALT=1).
  - ControlWord=NOP, constant=0, halted=0.
  - Reset mid-instruction aborts it; no RegW or MemW is asserted in the following cycle.
- States: FETCH(0), DECODE(1), EX0(2), EX1(3), HALT(7).
- FETCH:
  - Emits bus=11, IR_Ld=1, PC_En=1, PS=01.
  - Next state DECODE.
- DECODE:
  - Emits NOP.
  - Decodes IR[31:21] and loads constant.
  - Next state EX0, or HALT on an unsupported opcode.
- EX0 by opcode:
  - R-type ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000:
    - DA=IR[4:0], SA=IR[9:5], SB=IR[20:16].
    - RegW=1, bus=00. SUB sets C0=1 and FS=01001.
    - Next FETCH.
  - ADDI 1001000100x / SUBI 1101000100x:
    - constant = zero-extended IR[21:10].
    - BSel=1, RegW=1. SUBI sets C0=1.
    - Next FETCH.
  - LDUR 11111000010:
    - EX0 computes the address: FS=ADD, BSel=1, constant = sign-extended IR[20:12].
    - EX1 writes back: bus=11, RegW=1, DA=IR[4:0], address operands held.
    - Next FETCH.
  - STUR 11111000000:
    - FS=ADD, BSel=1, SB=IR[4:0], bus=01, MemW=1.
    - Next FETCH.
  - B 000101:
    - constant = sign-extended {IR[25:0],2'b00}, computed relative to the fetched PC.
    - PS=11, PC_En=1.
    - Next FETCH.
  - CBZ 10110100:
    - constant = sign-extended {IR[23:5],2'b00}.
    - EX0: SA=IR[4:0], FS=pass A, SL=1.
    - EX1: if status[0] (Z)==1 then PS=11, PC_En=1; otherwise NOP.
    - Next FETCH.
- Branch offsets are relative to PC+4 of the fetched instruction. The datapath subtracts 4 internally; this block does not adjust for it.
- Arithmetic on constant: 64-bit two's complement; sign extension from the field MSB.
- HALT:
  - Emits NOP and halted=1.
  - Left only by reset.
- An IR change outside DECODE is ignored; the opcode is latched in DECODE.

Optional Feature:
- Macro: LEGV8_CU_FLAGSET_EN.
- Defined:
  - Adds ADDS 10101011000 and SUBS 11101011000: as ADD/SUB with SL=1.
  - Adds B.cond 01010100, cond=IR[3:0]: EQ, NE, LT, GE, GT, LE, per the standard ARMv8 condition tests on status.
    - EX0 emits NOP; the condition is evaluated in EX1.
    - Taken: PS=11, PC_En=1, constant = sign-extended {IR[23:5],2'b00}.
- Undefined: these opcodes go to HALT; SL is never asserted except by CBZ.

Test Plan:
- Hold reset=0 for 2 cycles, then release → first cycle after release is FETCH with IR_Ld=1, PS=01, PC_En=1; ControlWord was NOP (0x0_0006_7FFF) during reset.
- IR=0x8B020023 (ADD X3,X1,X2) → DECODE, then EX0 with DA=3, SA=1, SB=2, FS=01000, RegW=1, C0=0; back to FETCH on the 4th cycle.
- IR=0xF84083E2 (LDUR X2,[X31,#8]) → constant=8; EX0 FS=ADD, BSel=1; EX1 bus=11, RegW=1, DA=2; 5 cycles total.
- IR=0xB4FFFFC1 (CBZ X1,#-2) with status=4'b0001 in EX1 → constant=0xFFFF_FFFF_FFFF_FFF8, PS=11, PC_En=1. With status=0 → EX1 is NOP.
- IR=0xFFFFFFFF → HALT after DECODE, halted=1, NOP held for 10 cycles; reset=0 returns to FETCH.
- Assert reset during LDUR EX0 → next ControlWord is NOP with RegW=0 and MemW=0, state=FETCH after release.
